// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and
// the sizing helper for the bit counter.
package serial_subtractor_pkg;

  // Operation sequencing: wait for a request, shift WIDTH bits, publish result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bit counter width: must be able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout = borrow out.
// Purely combinational; time-multiplexed by the serial datapath.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow generated when a < b + bin.
  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first, one bit per clock,
// using a single full-subtractor cell and a borrow flip-flop.
// Optional feature: define SERIAL_SUB_OVF_EN to add the signed-overflow
// output ovf (sign bits of a and b are then captured at start).
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             cell_d;
  logic             cell_bout;
  logic             last_bit;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_s;
  logic             b_s;
`endif

  // The single arithmetic cell always looks at the current LSBs and borrow.
  full_subtractor u_cell (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (br),
    .d    (cell_d),
    .bout (cell_bout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign busy     = (state == RUN);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only looked at in IDLE, so requests made
  // during RUN or DONE are dropped without disturbing the operation.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start)    state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:                  state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Serial datapath: capture operands, shift one bit per cycle, publish borrow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa   <= '0;
      sb   <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
      done <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_s  <= 1'b0;
      b_s  <= 1'b0;
      ovf  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_s <= a[WIDTH-1];
            b_s <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          diff <= {cell_d, diff[WIDTH-1:1]};
          sa   <= {1'b0, sa[WIDTH-1:1]};
          sb   <= {1'b0, sb[WIDTH-1:1]};
          br   <= cell_bout;
          cnt  <= cnt + CW'(1);
        end
        DONE: begin
          done <= 1'b1;
          bout <= br;
`ifdef SERIAL_SUB_OVF_EN
          // Overflow only possible when operand signs differ and the
          // result sign departs from the minuend sign.
          ovf  <= (a_s != b_s) && (diff[WIDTH-1] != a_s);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4), hand-computed vectors.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int checks = 0;
  int passed = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Launch one operation and follow it to done, checking busy span,
  // latency (posedges after the accepting edge) and results.
  task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_,
                        input logic tbin, input logic [3:0] ediff, input logic ebout,
                        input logic eovf);
    int n;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~ta; b = ~tb_; bin = ~tbin;
    n = 0;
    busy_cnt = 0;
    seen = 1'b0;
    if (busy) busy_cnt++;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'd5);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
    check({tag, "_diff"}, 32'(diff), 32'(ediff));
    check({tag, "_bout"}, 32'(bout), 32'(ebout));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) $display("unused");
`endif
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_diff_held"}, 32'(diff), 32'(ediff));
    $display("op %s: a=%0h b=%0h bin=%0d -> diff=%0h bout=%0d latency=%0d", tag, ta, tb_, tbin, diff, bout, n);
  endtask

  initial begin
    int dones;
    start = 1'b0; a = '0; b = '0; bin = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst_n = 1'b1;

    // Ovf column: 9-3 and 3-9 overflow as signed 4-bit values.
    run_op("t1_9m3", 4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 1'b1);
    run_op("t2_3m9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1);
    run_op("t3_7m2m1", 4'd7, 4'd2, 1'b1, 4'h4, 1'b0, 1'b0);
    run_op("t3_0m0m1", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);

    // Start while busy is ignored.
    @(negedge clk);
    a = 4'd5; b = 4'd1; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd0; b = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        check("t4_diff", 32'(diff), 32'h4);
        check("t4_bout", 32'(bout), 32'd0);
      end
    end
    check("t4_single_done", 32'(dones), 32'd1);
    $display("op t4: a=5 b=1 with ignored second start -> dones=%0d diff=%0h", dones, diff);

    // Asynchronous reset mid-run.
    @(negedge clk);
    a = 4'd9; b = 4'd3; bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("t5_busy_before_rst", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_diff", 32'(diff), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("t5_no_done", 32'(dones), 32'd0);
    $display("op t5: reset during run -> dones=%0d", dones);
    run_op("t5_8m8", 4'd8, 4'd8, 1'b0, 4'h0, 1'b0, 1'b0);

    run_op("t6_7m8", 4'd7, 4'd8, 1'b0, 4'hF, 1'b1, 1'b1);
    run_op("t6_2m1", 4'd2, 4'd1, 1'b0, 4'h1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
